// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Definitions shared by the AXI-stream blocks.
//   STATE_IDLE / STATE_LOCKED : arbiter FSM encoding
//   clog2_min1()              : counter width that is never zero bits
// No ports (package).
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  // $clog2 returns 0 for n<=1, which cannot size a vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter_if
// Bundles the N_PORTS source streams and the single merged sink stream.
//   s_axis_tdata  : N_PORTS*DATA_WIDTH, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid : per-source valid
//   s_axis_tready : per-source ready (at most one bit high)
//   m_axis_tdata  : merged data
//   m_axis_tid    : source index of the current merged beat
//   m_axis_tvalid : merged valid
//   m_axis_tready : downstream ready
// Modports: slave  = arbiter side (consumes the sources, drives the sink)
//           master = environment side (drives the sources, consumes the sink)
// -----------------------------------------------------------------------------
interface axis_rr_arbiter_if
  import axis_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(N_PORTS)
);

  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [N_PORTS-1:0]            s_axis_tvalid;
  logic [N_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [ID_WIDTH-1:0]           m_axis_tid;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );

endinterface

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational rotating priority encoder: returns the first asserted request
// found scanning base_i, base_i+1, ... wrapping from N_PORTS-1 to 0.
//   req_i  : request vector
//   base_i : index with highest priority
//   idx_o  : winning index (equals base_i when nothing is requested)
//   any_o  : at least one request asserted
// -----------------------------------------------------------------------------
module rr_priority_select
  import axis_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int ID_WIDTH = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] base_i,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                any_o
);

  // (b + k) mod N_PORTS without relying on N_PORTS being a power of two.
  function automatic logic [ID_WIDTH-1:0] rot(input logic [ID_WIDTH-1:0] b,
                                              input int k);
    int s;
    s = int'(b) + k;
    if (s >= N_PORTS) s = s - N_PORTS;
    return ID_WIDTH'(s);
  endfunction

  // Scan from lowest priority to highest so the last hit written wins.
  always_comb begin
    idx_o = base_i;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req_i[rot(base_i, k)]) idx_o = rot(base_i, k);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Round-robin merge of N_PORTS AXI-stream sources onto one registered sink.
// A grant lasts up to BURST_LEN beats or until the granted source idles; each
// new grant costs one arbitration cycle. Output beats carry their source index.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : axis_rr_arbiter_if.slave (sources in, merged stream out)
// -----------------------------------------------------------------------------
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = $clog2(N_PORTS)
) (
  input logic            clk,
  input logic            rst,
  axis_rr_arbiter_if.slave bus
);

  localparam int                  BCNT_W    = clog2_min1(BURST_LEN);
  localparam logic [BCNT_W-1:0]   LAST_BEAT = BCNT_W'(BURST_LEN - 1);
  localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(N_PORTS - 1);

  logic                  state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [BCNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic                  tvalid_q, tvalid_d;

  logic [DATA_WIDTH-1:0] src_data [N_PORTS];
  logic [N_PORTS-1:0]    s_tready;
  logic [ID_WIDTH-1:0]   sel_idx, next_ptr;
  logic                  sel_any, out_free, grant_vld, accept;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign src_data[g] = bus.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_select #(
    .N_PORTS  (N_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_sel (
    .req_i  (bus.s_axis_tvalid),
    .base_i (rr_ptr_q),
    .idx_o  (sel_idx),
    .any_o  (sel_any)
  );

  // The output slot can take a beat if it is empty or being drained this cycle.
  assign out_free  = !tvalid_q || bus.m_axis_tready;
  assign grant_vld = bus.s_axis_tvalid[grant_q];
  assign accept    = (state_q == STATE_LOCKED) && grant_vld && out_free;
  assign next_ptr  = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STATE_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tid_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tid_q      <= tid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      STATE_IDLE: begin
        if (sel_any) begin
          state_d    = STATE_LOCKED;
          grant_d    = sel_idx;
          beat_cnt_d = '0;
        end
      end
      default: begin
        if (accept && (beat_cnt_q == LAST_BEAT)) begin
          // Counter parks at zero so it never exceeds BURST_LEN-1.
          state_d    = STATE_IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (!grant_vld) begin
          state_d  = STATE_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
    endcase
  end

  // Outputs: source ready and output register load/drain
  always_comb begin
    s_tready = '0;
    if (state_q == STATE_LOCKED) s_tready[grant_q] = out_free;
    tvalid_d = tvalid_q && !bus.m_axis_tready;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = src_data[grant_q];
      tid_d    = grant_q;
    end
  end

  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed bench for axis_rr_arbiter (N_PORTS=4, DATA_WIDTH=8, BURST_LEN=4).
// Each source is a counter stream: data = base + beats sent, valid while it
// still has beats left. Output beats are encoded as {tid, tdata}, -1 = idle.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.N_PORTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axis_rr_arbiter #(
    .N_PORTS    (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .ID_WIDTH   (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int src_base [N];
  int src_n    [N];
  int src_left [N];
  int beat_log [$];
  int cyc_log  [$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mout();
    return bus.m_axis_tvalid ? int'({bus.m_axis_tid, bus.m_axis_tdata}) : -1;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i]         = (src_left[i] > 0);
      bus.s_axis_tdata[i*DW +: DW] = DW'(src_base[i] + src_n[i]);
    end
  endtask

  task automatic clr_src();
    for (int i = 0; i < N; i++) begin
      src_base[i] = 0;
      src_n[i]    = 0;
      src_left[i] = 0;
    end
    drive_src();
  endtask

  // One clock: sample handshakes at the falling edge, advance sources after
  // the rising edge. Sources ignore ready while rst is high.
  task automatic step();
    logic [N-1:0] fired;
    @(negedge clk);
    fired = rst ? '0 : (bus.s_axis_tvalid & bus.s_axis_tready);
    cyc_log.push_back(mout());
    if (bus.m_axis_tvalid && bus.m_axis_tready) beat_log.push_back(mout());
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        src_n[i]++;
        src_left[i]--;
      end
    end
    drive_src();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    cyc_log.delete();
    beat_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c [18];
    int exp_s [12];
    int exp_e [8];

    bus.m_axis_tready = 1'b1;
    clr_src();

    // ---- Reset with all sources valid ----
    for (int i = 0; i < N; i++) begin
      src_base[i] = 'hA0 + 16 * i;
      src_left[i] = 1000;
    end
    drive_src();
    do_reset(2);
    chk("rst_tvalid", int'(bus.m_axis_tvalid), 0);
    chk("rst_tready", int'(bus.s_axis_tready), 0);
    chk("rst_tdata",  int'(bus.m_axis_tdata), 0);
    chk("rst_tid",    int'(bus.m_axis_tid), 0);
    step();
    chk("arb_tready", int'(bus.s_axis_tready), 'b0001);
    chk("arb_tvalid", int'(bus.m_axis_tvalid), 0);
    step();
    chk("first_beat", mout(), 'h0A0);

    // ---- Contention: ports 0,1,3 always valid ----
    clr_src();
    src_base[0] = 'hA0; src_left[0] = 1000;
    src_base[1] = 'hB0; src_left[1] = 1000;
    src_base[3] = 'hD0; src_left[3] = 1000;
    drive_src();
    do_reset(1);
    repeat (18) step();
    exp_c = '{-1, -1, 'h0A0, 'h0A1, 'h0A2, 'h0A3, -1,
              'h1B0, 'h1B1, 'h1B2, 'h1B3, -1,
              'h3D0, 'h3D1, 'h3D2, 'h3D3, -1, 'h0A4};
    chk("cont_len", cyc_log.size(), 18);
    for (int i = 0; i < 18 && i < cyc_log.size(); i++)
      chk($sformatf("cont_cyc%0d", i), cyc_log[i], exp_c[i]);

    // ---- Single source: port 2 streams 0x10..0x17 ----
    clr_src();
    src_base[2] = 'h10; src_left[2] = 8;
    drive_src();
    do_reset(1);
    repeat (12) step();
    exp_s = '{-1, -1, 'h210, 'h211, 'h212, 'h213, -1,
              'h214, 'h215, 'h216, 'h217, -1};
    chk("single_len", cyc_log.size(), 12);
    for (int i = 0; i < 12 && i < cyc_log.size(); i++)
      chk($sformatf("single_cyc%0d", i), cyc_log[i], exp_s[i]);

    // ---- Backpressure during a port 1 burst ----
    clr_src();
    src_base[1] = 'h54; src_left[1] = 4;
    drive_src();
    do_reset(1);
    repeat (3) step();
    bus.m_axis_tready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_hold%0d", c), mout(), 'h155);
      chk($sformatf("bp_rdy%0d", c), int'(bus.s_axis_tready), 0);
      step();
    end
    chk("bp_hold3", mout(), 'h155);
    bus.m_axis_tready = 1'b1;
    #1;
    chk("bp_release_rdy", int'(bus.s_axis_tready), 'b0010);
    step();
    chk("bp_next", mout(), 'h156);
    repeat (3) step();
    chk("bp_beats", beat_log.size(), 4);
    for (int i = 0; i < 4 && i < beat_log.size(); i++)
      chk($sformatf("bp_beat%0d", i), beat_log[i], 'h154 + i);

    // ---- Early release: port 0 idles after 2 beats, port 3 waiting ----
    clr_src();
    src_base[0] = 'hA0; src_left[0] = 2;
    src_base[3] = 'hD0; src_left[3] = 4;
    drive_src();
    do_reset(1);
    repeat (3) step();
    chk("early_locked0", int'(bus.s_axis_tready), 'b0001);
    step();
    chk("early_idle", int'(bus.s_axis_tready), 0);
    step();
    chk("early_grant3", int'(bus.s_axis_tready), 'b1000);
    src_left[0] = 2;
    drive_src();
    repeat (10) step();
    exp_e = '{'h0A0, 'h0A1, 'h3D0, 'h3D1, 'h3D2, 'h3D3, 'h0A2, 'h0A3};
    chk("early_beats", beat_log.size(), 8);
    for (int i = 0; i < 8 && i < beat_log.size(); i++)
      chk($sformatf("early_beat%0d", i), beat_log[i], exp_e[i]);

    // ---- Mid-burst reset: rr_ptr moved to 2 before the reset ----
    clr_src();
    src_base[1] = 'hB0; src_left[1] = 1;
    src_base[2] = 'hC0; src_left[2] = 100;
    drive_src();
    do_reset(1);
    repeat (6) step();
    chk("mid_beat2", mout(), 'h2C1);
    rst = 1'b1;
    src_base[0] = 'hA0; src_left[0] = 100;
    drive_src();
    step();
    chk("mid_rst_tvalid", int'(bus.m_axis_tvalid), 0);
    chk("mid_rst_tready", int'(bus.s_axis_tready), 0);
    rst = 1'b0;
    step();
    chk("mid_regrant0", int'(bus.s_axis_tready), 'b0001);
    step();
    chk("mid_first", mout(), 'h0A0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
